// File: rtl/alu_op_sequencer_pkg.sv
// rtl/alu_op_sequencer_pkg.sv - shared LC-3 operate-instruction constants, FSM states and helpers
package alu_op_sequencer_pkg;

  // Opcodes handled by the sequencer
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  // ALU function codes; PASSA exists in the datapath but is never issued here
  typedef enum logic [1:0] {
    ALUK_ADD   = 2'b00,
    ALUK_AND   = 2'b01,
    ALUK_NOT   = 2'b10,
    ALUK_PASSA = 2'b11
  } aluk_t;

  // Register-file address mux selects
  localparam logic [2:0] SR1MUX_NONE    = 3'b000;
  localparam logic [2:0] SR1MUX_IR_8_6  = 3'b001;
  localparam logic [2:0] DRMUX_IR_11_9  = 3'b000;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  // True for the three operate opcodes this block can execute
  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // ALU function for an opcode; anything unrecognised falls back to ADD
  function automatic aluk_t aluk_for(input logic [3:0] op);
    case (op)
      OP_AND:  return ALUK_AND;
      OP_NOT:  return ALUK_NOT;
      default: return ALUK_ADD;
    endcase
  endfunction

  // Condition codes {N,Z,P} of a 16-bit two's-complement value; exactly one bit set
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])
      return 3'b100;
    else if (v == 16'h0000)
      return 3'b010;
    else
      return 3'b001;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - instruction handshake, bus and datapath control bundle
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;

  logic [15:0] i_instr;
  logic        i_instr_vld;
  logic        o_instr_rdy;
  logic [15:0] i_bus;
  logic [1:0]  o_ALUK;
  logic [2:0]  o_SR1MUX;
  logic [2:0]  o_DRMUX;
  logic [2:0]  o_IR_11_9;
  logic [2:0]  o_IR_8_6;
  logic [2:0]  o_IR_2_0;
  logic        o_IR_5;
  logic [4:0]  o_IR_4_0;
  logic        o_GateALU;
  logic        o_LD_REG;
  logic [2:0]  o_NZP;
  logic        o_done;
  logic        o_illegal;

  // Instruction source / datapath side
  modport master (
    output i_instr, i_instr_vld, i_bus,
    input  o_instr_rdy, o_ALUK, o_SR1MUX, o_DRMUX, o_IR_11_9, o_IR_8_6,
           o_IR_2_0, o_IR_5, o_IR_4_0, o_GateALU, o_LD_REG, o_NZP,
           o_done, o_illegal
  );

  // Sequencer side
  modport slave (
    input  i_instr, i_instr_vld, i_bus,
    output o_instr_rdy, o_ALUK, o_SR1MUX, o_DRMUX, o_IR_11_9, o_IR_8_6,
           o_IR_2_0, o_IR_5, o_IR_4_0, o_GateALU, o_LD_REG, o_NZP,
           o_done, o_illegal
  );

endinterface

// File: rtl/alu_op_sequencer_nzp_reg.sv
// rtl/alu_op_sequencer_nzp_reg.sv - condition-code register loaded from a 16-bit write-back value
module nzp_reg
  import alu_op_sequencer_pkg::*;
#(
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_ld,
  input  logic [15:0] i_value,
  output logic [2:0]  o_nzp
);

  logic [2:0] nzp_q;

  // Capture the sign/zero classification of the written-back value when loaded
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N)
      nzp_q <= NZP_RESET;
    else if (i_ld)
      nzp_q <= nzp_of(i_value);
  end

  assign o_nzp = nzp_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - control FSM sequencing reg file + ALU for LC-3 ADD/AND/NOT
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter bit         SETCC_EN  = 1'b1,
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  alu_op_sequencer_if.slave    sif
);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] ir_q;
  logic        legal;
  logic        rdy_state;
  aluk_t       aluk;
  logic [2:0]  sr1mux;
  logic [2:0]  drmux;
  logic        gate_alu;
  logic        ld_reg;
  logic        done;
  logic        illegal;
  logic        nzp_ld;

  assign legal = is_legal(ir_q[15:12]);

  // State register and instruction capture; IR only loads on an IDLE handshake
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= ST_IDLE;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && sif.i_instr_vld)
        ir_q <= sif.i_instr;
    end
  end

  // Next-state: illegal opcodes skip EXEC so nothing is ever written back
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sif.i_instr_vld) state_d = ST_DECODE;
      ST_DECODE: state_d = legal ? ST_EXEC : ST_DONE;
      ST_EXEC:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from state and captured opcode
  always_comb begin
    rdy_state = 1'b0;
    aluk      = ALUK_ADD;
    sr1mux    = SR1MUX_NONE;
    drmux     = DRMUX_IR_11_9;
    gate_alu  = 1'b0;
    ld_reg    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_state = 1'b1;
      end
      ST_DECODE: begin
        sr1mux = SR1MUX_IR_8_6;
        drmux  = DRMUX_IR_11_9;
        aluk   = aluk_for(ir_q[15:12]);
      end
      ST_EXEC: begin
        sr1mux   = SR1MUX_IR_8_6;
        drmux    = DRMUX_IR_11_9;
        aluk     = aluk_for(ir_q[15:12]);
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = ~legal;
      end
      default: begin
        rdy_state = 1'b0;
      end
    endcase
  end

  // Condition codes follow the bus value at the write-back edge
  assign nzp_ld = SETCC_EN && (state_q == ST_EXEC);

  nzp_reg #(
    .NZP_RESET (NZP_RESET)
  ) u_nzp_reg (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_ld    (nzp_ld),
    .i_value (sif.i_bus),
    .o_nzp   (sif.o_NZP)
  );

  // Ready is held low while reset is asserted, not just after the state clears
  assign sif.o_instr_rdy = rdy_state & i_RST_N;
  assign sif.o_ALUK      = aluk;
  assign sif.o_SR1MUX    = sr1mux;
  assign sif.o_DRMUX     = drmux;
  assign sif.o_GateALU   = gate_alu;
  assign sif.o_LD_REG    = ld_reg;
  assign sif.o_done      = done;
  assign sif.o_illegal   = illegal;
  assign sif.o_IR_11_9   = ir_q[11:9];
  assign sif.o_IR_8_6    = ir_q[8:6];
  assign sif.o_IR_2_0    = ir_q[2:0];
  assign sif.o_IR_5      = ir_q[5];
  assign sif.o_IR_4_0    = ir_q[4:0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench with a reg file + ALU model
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_op_sequencer_if sif ();

  alu_op_sequencer #(
    .SETCC_EN  (1'b1),
    .NZP_RESET (3'b010)
  ) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .sif     (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // processing_unit model: reg file + ALU driving the bus under GateALU
  logic [15:0] regs [8];
  logic [15:0] sr1_val;
  logic [15:0] sr2_val;
  logic [15:0] alu_out;
  logic        pre_en;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;

  always_comb begin
    sr1_val = regs[sif.o_IR_8_6];
    sr2_val = sif.o_IR_5 ? {{11{sif.o_IR_4_0[4]}}, sif.o_IR_4_0} : regs[sif.o_IR_2_0];
    case (sif.o_ALUK)
      2'b00:   alu_out = sr1_val + sr2_val;
      2'b01:   alu_out = sr1_val & sr2_val;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
    sif.i_bus = sif.o_GateALU ? alu_out : 16'h0000;
  end

  always @(posedge clk) begin
    if (pre_en)
      regs[pre_addr] <= pre_data;
    else if (sif.o_LD_REG)
      regs[sif.o_IR_11_9] <= sif.i_bus;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Present instr at a negedge; the next posedge is accept edge T; returns at negedge of cycle T+1
  task automatic accept(input logic [15:0] instr);
    sif.i_instr     = instr;
    sif.i_instr_vld = 1'b1;
    @(posedge clk);
    #1 sif.i_instr_vld = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    pre_en = 1'b0;
    pre_addr = 3'd0;
    pre_data = 16'h0000;
    sif.i_instr = 16'h0000;
    sif.i_instr_vld = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdy", 16'(sif.o_instr_rdy), 16'h0);
    chk("rst_nzp", 16'(sif.o_NZP), 16'h2);
    chk("rst_ld", 16'(sif.o_LD_REG), 16'h0);
    chk("rst_done", 16'(sif.o_done), 16'h0);
    chk("rst_ir", 16'(sif.o_IR_11_9), 16'h0);
    rst_n = 1'b1;
    #1 chk("rst_rel_rdy", 16'(sif.o_instr_rdy), 16'h1);
    @(negedge clk);

    // 1. ADD R1,R2,R3
    preload(3'd2, 16'd5);
    preload(3'd3, 16'd7);
    accept(16'h1283);
    chk("t1_aluk", 16'(sif.o_ALUK), 16'h0);
    chk("t1_sr1mux", 16'(sif.o_SR1MUX), 16'h1);
    chk("t1_drmux", 16'(sif.o_DRMUX), 16'h0);
    chk("t1_ir86", 16'(sif.o_IR_8_6), 16'h2);
    chk("t1_ir20", 16'(sif.o_IR_2_0), 16'h3);
    chk("t1_dec_ld", 16'(sif.o_LD_REG), 16'h0);
    chk("t1_dec_gate", 16'(sif.o_GateALU), 16'h0);
    chk("t1_dec_rdy", 16'(sif.o_instr_rdy), 16'h0);
    @(negedge clk);
    chk("t1_ex_ld", 16'(sif.o_LD_REG), 16'h1);
    chk("t1_ex_gate", 16'(sif.o_GateALU), 16'h1);
    chk("t1_ex_bus", sif.i_bus, 16'd12);
    @(negedge clk);
    chk("t1_done", 16'(sif.o_done), 16'h1);
    chk("t1_illegal", 16'(sif.o_illegal), 16'h0);
    chk("t1_done_ld", 16'(sif.o_LD_REG), 16'h0);
    chk("t1_done_sr1", 16'(sif.o_SR1MUX), 16'h0);
    chk("t1_nzp", 16'(sif.o_NZP), 16'h1);
    chk("t1_r1", regs[1], 16'd12);
    @(negedge clk);
    chk("t1_idle_rdy", 16'(sif.o_instr_rdy), 16'h1);
    chk("t1_idle_done", 16'(sif.o_done), 16'h0);

    // 2. ADD R1,R1,#-1
    preload(3'd1, 16'h0000);
    accept(16'h127F);
    chk("t2_ir5", 16'(sif.o_IR_5), 16'h1);
    chk("t2_ir40", 16'(sif.o_IR_4_0), 16'h1F);
    @(negedge clk);
    chk("t2_bus", sif.i_bus, 16'hFFFF);
    @(negedge clk);
    chk("t2_r1", regs[1], 16'hFFFF);
    chk("t2_nzp", 16'(sif.o_NZP), 16'h4);
    @(negedge clk);

    // 3. AND R0,R0,#0
    preload(3'd0, 16'h1234);
    accept(16'h5020);
    chk("t3_aluk", 16'(sif.o_ALUK), 16'h1);
    @(negedge clk);
    chk("t3_ld", 16'(sif.o_LD_REG), 16'h1);
    @(negedge clk);
    chk("t3_r0", regs[0], 16'h0000);
    chk("t3_nzp", 16'(sif.o_NZP), 16'h2);
    @(negedge clk);

    // 4. NOT R4,R5
    preload(3'd5, 16'h00FF);
    accept(16'h997F);
    chk("t4_aluk", 16'(sif.o_ALUK), 16'h2);
    @(negedge clk);
    chk("t4_bus", sif.i_bus, 16'hFF00);
    @(negedge clk);
    chk("t4_r4", regs[4], 16'hFF00);
    chk("t4_nzp", 16'(sif.o_NZP), 16'h4);
    @(negedge clk);

    // 5. Illegal TRAP: DECODE -> DONE
    accept(16'hF025);
    chk("t5_dec_gate", 16'(sif.o_GateALU), 16'h0);
    chk("t5_dec_ld", 16'(sif.o_LD_REG), 16'h0);
    @(negedge clk);
    chk("t5_done", 16'(sif.o_done), 16'h1);
    chk("t5_illegal", 16'(sif.o_illegal), 16'h1);
    chk("t5_ld", 16'(sif.o_LD_REG), 16'h0);
    chk("t5_nzp", 16'(sif.o_NZP), 16'h4);
    @(negedge clk);
    chk("t5_idle_rdy", 16'(sif.o_instr_rdy), 16'h1);

    // 6a. Reset during EXEC aborts without write-back
    accept(16'h1283);
    @(negedge clk);
    chk("t6_ex_ld", 16'(sif.o_LD_REG), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ld", 16'(sif.o_LD_REG), 16'h0);
    chk("t6_rst_gate", 16'(sif.o_GateALU), 16'h0);
    chk("t6_rst_aluk", 16'(sif.o_ALUK), 16'h0);
    chk("t6_rst_nzp", 16'(sif.o_NZP), 16'h2);
    chk("t6_rst_rdy", 16'(sif.o_instr_rdy), 16'h0);
    chk("t6_rst_ir", 16'(sif.o_IR_11_9), 16'h0);
    @(posedge clk);
    #1 chk("t6_r1_kept", regs[1], 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_rel_rdy", 16'(sif.o_instr_rdy), 16'h1);
    @(negedge clk);

    // 6b. vld in DONE is ignored; accepted only once back in IDLE
    accept(16'h5020);
    repeat (2) @(negedge clk);
    chk("t6b_done", 16'(sif.o_done), 16'h1);
    sif.i_instr     = 16'h1283;
    sif.i_instr_vld = 1'b1;
    @(negedge clk);
    chk("t6b_idle_rdy", 16'(sif.o_instr_rdy), 16'h1);
    chk("t6b_ir_kept", 16'(sif.o_IR_11_9), 16'h0);
    @(posedge clk);
    #1 sif.i_instr_vld = 1'b0;
    @(negedge clk);
    chk("t6b_ir_new", 16'(sif.o_IR_11_9), 16'h1);
    chk("t6b_dec_rdy", 16'(sif.o_instr_rdy), 16'h0);
    repeat (3) @(negedge clk);
    chk("t6b_end_rdy", 16'(sif.o_instr_rdy), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
